// File: rtl/word_byte_pkg.sv
// Shared widths and FSM state encoding for the word-to-byte serializer.
package word_byte_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HI   = 2'b01,
    ST_LO   = 2'b10
  } tx_state_t;

endpackage

// File: rtl/word_byte_tx.sv
// Byte serializer: takes a 16-bit word on a valid/ready handshake and sends
// it on an 8-bit bus, high byte first, then low byte.
// Optional feature macro: WORD_BYTE_TX_PIPE_EN (accept the next word in the
// same cycle the low byte completes, giving 2 cycles per word).
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | no word held; ready for a new word
// ST_HI   | high byte on data_out, waiting for byte_ready
// ST_LO   | low byte on data_out, waiting for byte_ready
// 2'b11   | illegal; recovers to ST_IDLE
module word_byte_tx
  import word_byte_pkg::*;
(
  input  logic              clk1,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              abort,
  output logic [BYTE_W-1:0] data_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy
);

  tx_state_t         r_state;
  logic [WORD_W-1:0] r_hold;
  logic [BYTE_W-1:0] r_data_out;
  logic              r_byte_valid;

  tx_state_t         w_state_nxt;
  logic [BYTE_W-1:0] w_data_nxt;
  logic              w_byte_valid_nxt;
  logic              w_word_ready;
  logic              w_accept;

  // Ready is a pure function of state, abort and (pipelined build) byte_ready.
  always_comb begin
    w_word_ready = 1'b0;
    if (!abort) begin
      if (r_state == ST_IDLE) begin
        w_word_ready = 1'b1;
      end
`ifdef WORD_BYTE_TX_PIPE_EN
      else if (r_state == ST_LO) begin
        w_word_ready = byte_ready;
      end
`endif
    end
  end

  assign w_accept = word_valid && w_word_ready;

  // Next-state and next-output decode; abort overrides every state.
  always_comb begin
    w_state_nxt      = r_state;
    w_data_nxt       = r_data_out;
    w_byte_valid_nxt = r_byte_valid;
    if (abort) begin
      // hold and data_out deliberately left untouched
      w_state_nxt      = ST_IDLE;
      w_byte_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt      = ST_HI;
            w_data_nxt       = word_in[WORD_W-1:BYTE_W];
            w_byte_valid_nxt = 1'b1;
          end
        end
        ST_HI: begin
          if (byte_ready) begin
            w_state_nxt = ST_LO;
            w_data_nxt  = r_hold[BYTE_W-1:0];
          end
        end
        ST_LO: begin
          if (byte_ready) begin
            if (w_accept) begin
              // back-to-back word: stay valid, go straight to the new high byte
              w_state_nxt      = ST_HI;
              w_data_nxt       = word_in[WORD_W-1:BYTE_W];
              w_byte_valid_nxt = 1'b1;
            end else begin
              w_state_nxt      = ST_IDLE;
              w_byte_valid_nxt = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt      = ST_IDLE;
          w_byte_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_data_out   <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_data_out   <= w_data_nxt;
      r_byte_valid <= w_byte_valid_nxt;
    end
  end

  // Hold register captures the whole word on every accepted handshake.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (w_accept) begin
      r_hold <= word_in;
    end
  end

  assign word_ready = w_word_ready;
  assign data_out   = r_data_out;
  assign byte_valid = r_byte_valid;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_word_byte_tx.sv
// Directed bench for word_byte_tx. Inputs change 1 ns after the rising edge;
// outputs are checked there too, away from the edge.
module tb_word_byte_tx;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        abort;
  logic [7:0]  data_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  word_byte_tx dut (
    .clk1       (clk1),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .abort      (abort),
    .data_out   (data_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic bv, input logic [7:0] d, input logic bsy);
    chk({tag, ".byte_valid"}, {15'd0, byte_valid}, {15'd0, bv});
    chk({tag, ".data_out"},   {8'd0, data_out},    {8'd0, d});
    chk({tag, ".busy"},       {15'd0, busy},       {15'd0, bsy});
  endtask

  initial begin
    // reset with a valid word present
    rst = 1'b0; abort = 1'b0; byte_ready = 1'b0;
    word_valid = 1'b1; word_in = 16'hFFFF;
    cyc(); cyc();
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    word_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset.word_ready", {15'd0, word_ready}, 16'd1);
    cyc();
    chk_out("reset_idle", 1'b0, 8'h00, 1'b0);

    // single word, byte_ready high
    word_in = 16'hA55A; word_valid = 1'b1; byte_ready = 1'b1;
    #1;
    chk("a55a.ready_idle", {15'd0, word_ready}, 16'd1);
    cyc();
    chk_out("a55a.hi", 1'b1, 8'hA5, 1'b1);
    chk("a55a.ready_hi", {15'd0, word_ready}, 16'd0);
    word_valid = 1'b0;
    cyc();
    chk_out("a55a.lo", 1'b1, 8'h5A, 1'b1);
    cyc();
    chk_out("a55a.done", 1'b0, 8'h5A, 1'b0);

    // backpressure in HI; a second valid word must be ignored
    word_in = 16'h1234; word_valid = 1'b1; byte_ready = 1'b0;
    cyc();
    chk_out("bp.hi0", 1'b1, 8'h12, 1'b1);
    word_in = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.ready", {15'd0, word_ready}, 16'd0);
      cyc();
      chk_out("bp.hold", 1'b1, 8'h12, 1'b1);
    end
    word_valid = 1'b0; byte_ready = 1'b1;
    cyc();
    chk_out("bp.lo", 1'b1, 8'h34, 1'b1);
    cyc();
    chk_out("bp.done", 1'b0, 8'h34, 1'b0);

    // abort in LO after the high byte was taken
    word_in = 16'hBEEF; word_valid = 1'b1; byte_ready = 1'b1;
    cyc();
    chk_out("abort.hi", 1'b1, 8'hBE, 1'b1);
    word_valid = 1'b0;
    cyc();
    chk_out("abort.lo", 1'b1, 8'hEF, 1'b1);
    abort = 1'b1; byte_ready = 1'b0;
    #1;
    chk("abort.ready_low", {15'd0, word_ready}, 16'd0);
    cyc();
    chk_out("abort.after", 1'b0, 8'hEF, 1'b0);
    // abort in IDLE blocks acceptance
    word_in = 16'h5555; word_valid = 1'b1;
    #1;
    chk("abort.idle_ready", {15'd0, word_ready}, 16'd0);
    cyc();
    chk_out("abort.no_accept", 1'b0, 8'hEF, 1'b0);
    abort = 1'b0; word_valid = 1'b0;
    #1;
    chk("abort.ready_back", {15'd0, word_ready}, 16'd1);

    // back-to-back words
    word_in = 16'h0102; word_valid = 1'b1; byte_ready = 1'b1;
    cyc();
    chk_out("b2b.01", 1'b1, 8'h01, 1'b1);
    cyc();
    chk_out("b2b.02", 1'b1, 8'h02, 1'b1);
    word_in = 16'h0304;
`ifdef WORD_BYTE_TX_PIPE_EN
    #1;
    chk("b2b.ready_lo", {15'd0, word_ready}, 16'd1);
    cyc();
    chk_out("b2b.03", 1'b1, 8'h03, 1'b1);
`else
    #1;
    chk("b2b.ready_lo", {15'd0, word_ready}, 16'd0);
    cyc();
    chk_out("b2b.gap", 1'b0, 8'h02, 1'b0);
    cyc();
    chk_out("b2b.03", 1'b1, 8'h03, 1'b1);
`endif
    word_valid = 1'b0;
    cyc();
    chk_out("b2b.04", 1'b1, 8'h04, 1'b1);
    cyc();
    chk_out("b2b.done", 1'b0, 8'h04, 1'b0);

    // reset asserted mid-word
    word_in = 16'hCAFE; word_valid = 1'b1; byte_ready = 1'b0;
    cyc();
    chk_out("rstmid.hi", 1'b1, 8'hCA, 1'b1);
    word_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_out("rstmid.now", 1'b0, 8'h00, 1'b0);
    byte_ready = 1'b1;
    cyc();
    chk_out("rstmid.held", 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    cyc();
    chk_out("rstmid.nofe", 1'b0, 8'h00, 1'b0);
    cyc();
    chk_out("rstmid.idle", 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
